// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, ALU function codes, memory-width
// encodings and the packed control bundle carried by the decode stage.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] ALU_PASSB = 6'b000000;
    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_ADDU  = 6'b100001;
    localparam logic [5:0] ALU_SUB   = 6'b100010;
    localparam logic [5:0] ALU_AND   = 6'b100100;
    localparam logic [5:0] ALU_OR    = 6'b100101;
    localparam logic [5:0] ALU_XOR   = 6'b100110;
    localparam logic [5:0] ALU_SLT   = 6'b101010;
    localparam logic [5:0] ALU_SLTU  = 6'b101011;

    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_BYTE = 3'b001;
    localparam logic [2:0] MEM_HALF = 3'b010;
    localparam logic [2:0] MEM_WORD = 3'b100;

    typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} imm_ext_e;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       alu_src_imm;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_sign;
        logic       branch;
        logic       branch_eq;
        logic       jump;
        logic [2:0] mem_op;
    } ctrl_bundle_t;

    // Loads and stores encode access width in opcode[1:0].
    function automatic logic [2:0] mem_width(input logic [5:0] op);
        case (op[1:0])
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            2'b11:   return MEM_WORD;
            default: return MEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational MIPS decoder: instruction word to control bundle,
// register specifiers, extended immediate and jump target.
module ctrl_decode_comb
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instr,
    output ctrl_bundle_t          ctrl,
    output logic [DATA_W-1:0]     imm_ext,
    output logic [REG_ADDR_W-1:0] rs,
    output logic [REG_ADDR_W-1:0] rt,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [25:0]           jump_target,
    output logic                  uses_rt,
    output logic                  illegal,
    output logic                  halt
);

    logic [5:0]       opcode;
    logic [15:0]      imm;
    logic [DATA_W+31:0] lui_wide;
    imm_ext_e         ext_kind;

    assign opcode      = instr[31:26];
    assign imm         = instr[15:0];
    assign jump_target = instr[25:0];
    assign lui_wide    = {{DATA_W{1'b0}}, imm, 16'h0000};

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl     = '0;
        ext_kind = EXT_SIGN;
        uses_rt  = 1'b0;
        illegal  = 1'b0;
        halt     = 1'b0;
        rs       = REG_ADDR_W'(instr[25:21]);
        rt       = REG_ADDR_W'(instr[20:16]);
        dest     = rt;

        case (opcode)
            OP_RTYPE: begin
                ctrl.alu_op    = instr[5:0];
                ctrl.reg_write = 1'b1;
                dest           = REG_ADDR_W'(instr[15:11]);
                uses_rt        = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                case (opcode)
                    OP_ADDI:  ctrl.alu_op = ALU_ADD;
                    OP_ADDIU: ctrl.alu_op = ALU_ADDU;
                    OP_SLTI:  ctrl.alu_op = ALU_SLT;
                    default:  ctrl.alu_op = ALU_SLTU;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ext_kind         = EXT_ZERO;
                case (opcode)
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_XOR;
                endcase
            end
            OP_LUI: begin
                ctrl.alu_op      = ALU_PASSB;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ext_kind         = EXT_LUI;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                ctrl.alu_op      = ALU_ADD;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                ctrl.mem_sign    = ~opcode[2];
                ctrl.mem_op      = mem_width(opcode);
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.alu_op      = ALU_ADD;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
                ctrl.mem_op      = mem_width(opcode);
                uses_rt          = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op    = ALU_SUB;
                ctrl.branch    = 1'b1;
                ctrl.branch_eq = (opcode == OP_BEQ);
                uses_rt        = 1'b1;
            end
            OP_J:    ctrl.jump = 1'b1;
            OP_HALT: halt      = 1'b1;
            default: illegal   = 1'b1;
        endcase

        // $zero is never a real write-back target.
        if (dest == '0) ctrl.reg_write = 1'b0;

        case (ext_kind)
            EXT_ZERO: imm_ext = DATA_W'(imm);
            EXT_LUI:  imm_ext = lui_wide[DATA_W-1:0];
            default:  imm_ext = DATA_W'($signed(imm));
        endcase
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage: wraps the combinational decoder with valid/ready
// flow control, stall, flush, load-use bubble insertion, sticky halt and illegal flag.
module ctrl_decode_stage
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 6,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  alu_src_imm,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  mem_write,
    output logic                  mem_sign,
    output logic                  branch,
    output logic                  branch_eq,
    output logic                  jump,
    output logic [2:0]            mem_op,
    output logic [REG_ADDR_W-1:0] dest,
    output logic [REG_ADDR_W-1:0] rs,
    output logic [REG_ADDR_W-1:0] rt,
    output logic [DATA_W-1:0]     imm_ext,
    output logic [25:0]           jump_target,
    output logic                  illegal,
    output logic                  hazard_stall,
    output logic                  halted
);

    ctrl_bundle_t          d_ctrl, ctrl_q;
    logic [DATA_W-1:0]     d_imm, imm_q;
    logic [REG_ADDR_W-1:0] d_rs, d_rt, d_dest, rs_q, rt_q, dest_q;
    logic [25:0]           d_jt, jt_q;
    logic                  d_uses_rt, d_illegal, d_halt;
    logic                  out_valid_q, illegal_q, halted_q;
    logic                  load_in_stage, accept;

    ctrl_decode_comb #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .instr       (instr),
        .ctrl        (d_ctrl),
        .imm_ext     (d_imm),
        .rs          (d_rs),
        .rt          (d_rt),
        .dest        (d_dest),
        .jump_target (d_jt),
        .uses_rt     (d_uses_rt),
        .illegal     (d_illegal),
        .halt        (d_halt)
    );

    // A bubble clears out_valid, so the conflict disappears the following cycle.
    assign load_in_stage = out_valid_q && ctrl_q.mem_to_reg && (dest_q != '0);
    assign hazard_stall  = HAZARD_EN && load_in_stage && instr_valid &&
                           ((dest_q == d_rs) || ((dest_q == d_rt) && d_uses_rt));
    assign instr_ready   = !stall_in && !hazard_stall && !halted_q;
    assign accept        = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            jt_q        <= '0;
            illegal_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end else if (stall_in) begin
            out_valid_q <= out_valid_q;
        end else if (hazard_stall) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            ctrl_q      <= d_ctrl;
            imm_q       <= d_imm;
            rs_q        <= d_rs;
            rt_q        <= d_rt;
            dest_q      <= d_dest;
            jt_q        <= d_jt;
            illegal_q   <= d_illegal;
            if (d_halt) halted_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_op      = ALU_OP_W'(ctrl_q.alu_op);
    assign alu_src_imm = ctrl_q.alu_src_imm;
    assign reg_write   = ctrl_q.reg_write;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign mem_write   = ctrl_q.mem_write;
    assign mem_sign    = ctrl_q.mem_sign;
    assign branch      = ctrl_q.branch;
    assign branch_eq   = ctrl_q.branch_eq;
    assign jump        = ctrl_q.jump;
    assign mem_op      = ctrl_q.mem_op;
    assign dest        = dest_q;
    assign rs          = rs_q;
    assign rt          = rt_q;
    assign imm_ext     = imm_q;
    assign jump_target = jt_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage: hand-encoded MIPS words with
// hand-computed expected control bundles, hazards, stall, flush and halt.
module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid, instr_ready, stall_in, flush;
    logic        out_valid, alu_src_imm, reg_write, mem_to_reg, mem_write, mem_sign;
    logic        branch, branch_eq, jump, illegal, hazard_stall, halted;
    logic [5:0]  alu_op;
    logic [2:0]  mem_op;
    logic [4:0]  dest, rs, rt;
    logic [31:0] imm_ext;
    logic [25:0] jump_target;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [31:0] I_ADDI     = 32'h2009FFFF; // addi $t1,$zero,-1
    localparam logic [31:0] I_LW_T0    = 32'h8E080000; // lw   $t0,0($s0)
    localparam logic [31:0] I_ADD      = 32'h01095020; // add  $t2,$t0,$t1
    localparam logic [31:0] I_SW       = 32'hAE280004; // sw   $t0,4($s1)
    localparam logic [31:0] I_ORI_T0   = 32'h35080005; // ori  $t0,$t0,5
    localparam logic [31:0] I_ORI_ZERO = 32'h34080005; // ori  $t0,$zero,5
    localparam logic [31:0] I_LW_ZERO  = 32'h8E000000; // lw   $zero,0($s0)
    localparam logic [31:0] I_ADD_ZERO = 32'h00005020; // add  $t2,$zero,$zero
    localparam logic [31:0] I_LUI      = 32'h3C0B1234; // lui  $t3,0x1234
    localparam logic [31:0] I_ANDI     = 32'h3128FFFF; // andi $t0,$t1,0xffff
    localparam logic [31:0] I_BEQ      = 32'h1109FFFE; // beq  $t0,$t1,-2
    localparam logic [31:0] I_J        = 32'h08000010; // j    0x10
    localparam logic [31:0] I_ILL      = 32'hC1090000; // opcode 110000
    localparam logic [31:0] I_HALT     = 32'hFC000000;

    ctrl_decode_stage dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .stall_in     (stall_in),
        .flush        (flush),
        .out_valid    (out_valid),
        .alu_op       (alu_op),
        .alu_src_imm  (alu_src_imm),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .mem_write    (mem_write),
        .mem_sign     (mem_sign),
        .branch       (branch),
        .branch_eq    (branch_eq),
        .jump         (jump),
        .mem_op       (mem_op),
        .dest         (dest),
        .rs           (rs),
        .rt           (rt),
        .imm_ext      (imm_ext),
        .jump_target  (jump_target),
        .illegal      (illegal),
        .hazard_stall (hazard_stall),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] w);
        instr_valid = v;
        instr       = w;
    endtask

    initial begin
        reset = 1'b1;
        stall_in = 1'b0;
        flush = 1'b0;
        put(1'b0, 32'h0);
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_reg_write", 32'(reg_write), 0);
        check("rst_imm_ext", imm_ext, 0);
        check("rst_hazard", 32'(hazard_stall), 0);
        reset = 1'b0;

        // ADDI with negative immediate.
        put(1'b1, I_ADDI);
        #1 check("addi_ready", 32'(instr_ready), 1);
        tick();
        put(1'b0, 32'h0);
        check("addi_valid", 32'(out_valid), 1);
        check("addi_alu_op", 32'(alu_op), 32'h20);
        check("addi_src_imm", 32'(alu_src_imm), 1);
        check("addi_dest", 32'(dest), 9);
        check("addi_imm", imm_ext, 32'hFFFFFFFF);
        check("addi_reg_write", 32'(reg_write), 1);
        check("addi_mem_to_reg", 32'(mem_to_reg), 0);
        tick();
        check("idle_valid", 32'(out_valid), 0);

        // LW then dependent ADD through rs: one bubble, then ADD.
        put(1'b1, I_LW_T0);
        tick();
        check("lw_valid", 32'(out_valid), 1);
        check("lw_mem_to_reg", 32'(mem_to_reg), 1);
        check("lw_mem_op", 32'(mem_op), 32'h4);
        check("lw_mem_sign", 32'(mem_sign), 1);
        check("lw_dest", 32'(dest), 8);
        put(1'b1, I_ADD);
        #1 check("lu_add_hazard", 32'(hazard_stall), 1);
        check("lu_add_ready", 32'(instr_ready), 0);
        tick();
        check("lu_add_bubble", 32'(out_valid), 0);
        check("lu_add_bubble_m2r", 32'(mem_to_reg), 0);
        check("lu_add_hazard_drop", 32'(hazard_stall), 0);
        check("lu_add_ready_back", 32'(instr_ready), 1);
        tick();
        put(1'b0, 32'h0);
        check("add_valid", 32'(out_valid), 1);
        check("add_dest", 32'(dest), 10);
        check("add_alu_op", 32'(alu_op), 32'h20);
        check("add_src_imm", 32'(alu_src_imm), 0);
        check("add_rs_rt", {rs, rt}, {5'd8, 5'd9});

        // LW then SW using the loaded register as store data (rt).
        put(1'b1, I_LW_T0);
        tick();
        put(1'b1, I_SW);
        #1 check("lu_sw_hazard", 32'(hazard_stall), 1);
        tick();
        check("lu_sw_bubble", 32'(out_valid), 0);
        tick();
        put(1'b0, 32'h0);
        check("sw_valid", 32'(out_valid), 1);
        check("sw_mem_write", 32'(mem_write), 1);
        check("sw_reg_write", 32'(reg_write), 0);
        check("sw_imm", imm_ext, 32'h4);

        // LW then ORI reading the loaded register via rs.
        put(1'b1, I_LW_T0);
        tick();
        put(1'b1, I_ORI_T0);
        #1 check("lu_ori_hazard", 32'(hazard_stall), 1);
        tick();
        check("lu_ori_bubble", 32'(out_valid), 0);
        tick();
        put(1'b0, 32'h0);
        check("ori_alu_op", 32'(alu_op), 32'h25);

        // LW then ORI whose rt matches but is only a destination: no hazard.
        put(1'b1, I_LW_T0);
        tick();
        put(1'b1, I_ORI_ZERO);
        #1 check("ori_rt_no_hazard", 32'(hazard_stall), 0);
        tick();
        check("ori_valid", 32'(out_valid), 1);
        check("ori_imm", imm_ext, 32'h5);

        // Hold ORI under stall_in for three cycles, then flush during stall.
        put(1'b1, I_ADDI);
        stall_in = 1'b1;
        #1 check("stall_ready", 32'(instr_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 1);
            check("stall_alu_op", 32'(alu_op), 32'h25);
            check("stall_dest", 32'(dest), 8);
            check("stall_imm", imm_ext, 32'h5);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall_in = 1'b0;
        put(1'b0, 32'h0);
        check("flush_valid", 32'(out_valid), 0);

        // LW into $zero never creates a hazard.
        put(1'b1, I_LW_ZERO);
        tick();
        check("lwz_reg_write", 32'(reg_write), 0);
        check("lwz_mem_to_reg", 32'(mem_to_reg), 1);
        put(1'b1, I_ADD_ZERO);
        #1 check("lwz_no_hazard", 32'(hazard_stall), 0);
        tick();
        check("addz_valid", 32'(out_valid), 1);
        check("addz_dest", 32'(dest), 10);

        // Immediate forms, branch, jump, illegal.
        put(1'b1, I_LUI);
        tick();
        check("lui_imm", imm_ext, 32'h12340000);
        check("lui_reg_write", 32'(reg_write), 1);
        check("lui_alu_op", 32'(alu_op), 0);
        check("lui_dest", 32'(dest), 11);
        put(1'b1, I_ANDI);
        tick();
        check("andi_imm", imm_ext, 32'h0000FFFF);
        check("andi_dest", 32'(dest), 8);
        put(1'b1, I_BEQ);
        tick();
        check("beq_branch", {30'h0, branch, branch_eq}, 32'h3);
        check("beq_imm", imm_ext, 32'hFFFFFFFE);
        check("beq_reg_write", 32'(reg_write), 0);
        put(1'b1, I_J);
        tick();
        check("j_jump", 32'(jump), 1);
        check("j_target", 32'(jump_target), 32'h10);
        put(1'b1, I_ILL);
        tick();
        check("ill_valid", 32'(out_valid), 1);
        check("ill_illegal", 32'(illegal), 1);
        check("ill_reg_write", 32'(reg_write), 0);
        check("ill_mem_write", 32'(mem_write), 0);

        // HALT: sticky until reset, immune to flush.
        put(1'b1, I_HALT);
        tick();
        put(1'b1, I_ADDI);
        #1 check("halt_valid", 32'(out_valid), 1);
        check("halt_reg_write", 32'(reg_write), 0);
        check("halt_illegal", 32'(illegal), 0);
        check("halt_halted", 32'(halted), 1);
        check("halt_ready", 32'(instr_ready), 0);
        tick();
        check("halt_drain", 32'(out_valid), 0);
        check("halt_sticky", 32'(halted), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("halt_after_flush", 32'(halted), 1);
        reset = 1'b1;
        #1 check("halt_reset", 32'(halted), 0);
        check("halt_reset_valid", 32'(out_valid), 0);
        check("halt_reset_ready", 32'(instr_ready), 1);
        put(1'b0, 32'h0);
        tick();
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
